fifo_level: RTL and testbench
=============================

# fifo_level

Parametrised synchronous FIFO with occupancy tracking, run-time almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a selectable read mode (show-ahead or registered). It replaces the fixed full/empty-only FIFO as the standard buffer between producer and consumer blocks in the lab designs. It also lets a consumer throttle on a fill level instead of on full/empty alone.

## Interface
Parameters:
- nrOfEntries, 16, FIFO depth; power of two, ≥ 2
- bitWidth, 8, data width in bits
- showAhead, 1, 1 = head word visible on popData while not empty; 0 = popData registered, valid one cycle after pop

Ports:
- clock  in  1  single clock, all state changes on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately on assertion
- push  in  1  write request
- pushData  in  bitWidth  write data
- pop  in  1  read request
- popData  out  bitWidth  read data
- popValid  out  1  showAhead=0: high for one cycle when popData holds a newly popped word; showAhead=1: equals !empty
- full  out  1  fillLevel == nrOfEntries
- empty  out  1  fillLevel == 0
- fillLevel  out  $clog2(nrOfEntries)+1  number of stored words
- afLevel  in  $clog2(nrOfEntries)+1  almost-full threshold
- aeLevel  in  $clog2(nrOfEntries)+1  almost-empty threshold
- almostFull  out  1  fillLevel ≥ afLevel
- almostEmpty  out  1  fillLevel ≤ aeLevel
- overflow  out  1  sticky: push seen while full with no pop
- underflow  out  1  sticky: pop seen while empty
- clearErrors  in  1  synchronous clear of overflow/underflow

## Operation
- Write pointer, read pointer: $clog2(nrOfEntries) bits each, increment modulo nrOfEntries; wrap is natural overflow.
- Accepted push = push & (!full | pop). Accepted pop = pop & !empty.
- Push only: memory[wrPtr] ← pushData, wrPtr+1, fillLevel+1.
- Pop only: rdPtr+1, fillLevel−1.
- Both accepted: both pointers advance, fillLevel unchanged. This holds when full: the slot freed by the pop takes the new word.
- Push while empty with pop: pop rejected, underflow set, push accepted (fillLevel 0→1).
- Push while full without pop: data dropped, no state change, overflow set.
- Pop while empty: no state change, underflow set.
- clearErrors has priority over a same-cycle set; flags read 0 the following cycle.
- full, empty, almostFull, almostEmpty: combinational from the fillLevel register and the threshold inputs. Threshold changes take effect immediately.
- showAhead=1: popData = memory[rdPtr] combinationally. Value is don't-care while empty.
- showAhead=0: on an accepted pop, popData ← memory[rdPtr] and popValid ← 1. Otherwise popValid ← 0 and popData holds its value.

## Timing
- Reset (reset=0): pointers 0, fillLevel 0, empty 1, full 0, overflow 0, underflow 0, popData 0, popValid 0. almostEmpty = (aeLevel ≥ 0) = 1. almostFull = (afLevel == 0). Memory contents are not reset.
- Reset asserted mid-operation: all stored words are discarded; the first push after release lands at address 0.
- Write latency: a word pushed at edge n is readable (empty=0) after edge n. Under showAhead=1 it appears on popData in that same cycle.
- Read latency, showAhead=0: pop accepted at edge n → popData/popValid valid after edge n, for one cycle.
- fillLevel, full, empty and error flags all update on the same edge as the accepted operation.

## Structure
- Shared package `fifo_pkg`: function computing pointer/level widths from nrOfEntries; read-mode constants SHOW_AHEAD=1, REGISTERED=0.
- One sub-module, `fifo_dual_port_ram`: nrOfEntries × bitWidth, one synchronous write port, one asynchronous read port.
- Pointer/level/flag control and the showAhead=0 output register live in the top module.
- Elaboration check: error if nrOfEntries is not a power of two or is < 2.

## Test plan
All scenarios use nrOfEntries=8, bitWidth=8, afLevel=6, aeLevel=2.
- Reset mid-stream: push 3 words, assert reset asynchronously between edges → fillLevel 0 and empty 1 immediately, before the next edge; after release, push 0xAA → popData 0xAA (showAhead=1).
- Fill and drain: push 0x05..0x0C (8 words) → full=1 after the 8th edge, almostFull=1 from fillLevel 6. Pop 8 times → data 0x05..0x0C in order, empty=1, almostEmpty=1 from fillLevel 2.
- Overflow and clear: with the FIFO full, push 0xFF without pop → overflow=1, fillLevel stays 8, 0xFF never read. Pulse clearErrors → overflow=0.
- Simultaneous push and pop: full with push+pop for 10 cycles, pushData 0x20 upward → fillLevel stays 8, popped sequence continues in order across pointer wrap. Empty with push+pop → underflow=1, fillLevel 1.
- Registered mode (showAhead=0): push 0x11, 0x22; pop on two consecutive cycles → popValid high on the two following cycles, with popData 0x11 then 0x22; popValid low otherwise.
- Threshold change: at fillLevel 4, drive afLevel 4 → almostFull=1 in the same cycle; drive aeLevel 5 → almostEmpty=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared sizing helpers and read-mode constants
// for the fifo_level buffer and its storage.
package fifo_pkg;

   localparam int SHOW_AHEAD = 1;
   localparam int REGISTERED = 0;

   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int lvl_width(input int n);
      return $clog2(n) + 1;
   endfunction

   function automatic bit is_pow2(input int n);
      return (n >= 2) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/fifo_dual_port_ram.sv
// Storage array: one synchronous write port,
// one asynchronous read port. Contents are not reset.
module fifo_dual_port_ram
   import fifo_pkg::*;
#(
   parameter int depth = 16,
   parameter int width = 8
) (
   input  logic                        clock,
   input  logic                        wrEn,
   input  logic [ptr_width(depth)-1:0] wrAddr,
   input  logic [width-1:0]            wrData,
   input  logic [ptr_width(depth)-1:0] rdAddr,
   output logic [width-1:0]            rdData
);

   logic [width-1:0] r_mem [depth];

   always_ff @(posedge clock) begin
      if (wrEn) r_mem[wrAddr] <= wrData;
   end

   assign rdData = r_mem[rdAddr];

endmodule

// File: rtl/fifo_level.sv
// Synchronous FIFO with fill level, run-time thresholds,
// sticky error flags and show-ahead or registered read.
module fifo_level
   import fifo_pkg::*;
#(
   parameter int nrOfEntries = 16,
   parameter int bitWidth    = 8,
   parameter int showAhead   = SHOW_AHEAD
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                push,
   input  logic [bitWidth-1:0]                 pushData,
   input  logic                                pop,
   output logic [bitWidth-1:0]                 popData,
   output logic                                popValid,
   output logic                                full,
   output logic                                empty,
   output logic [lvl_width(nrOfEntries)-1:0]   fillLevel,
   input  logic [lvl_width(nrOfEntries)-1:0]   afLevel,
   input  logic [lvl_width(nrOfEntries)-1:0]   aeLevel,
   output logic                                almostFull,
   output logic                                almostEmpty,
   output logic                                overflow,
   output logic                                underflow,
   input  logic                                clearErrors
);

   localparam int PW = ptr_width(nrOfEntries);
   localparam int LW = lvl_width(nrOfEntries);
   localparam logic [LW-1:0] DEPTH = LW'(nrOfEntries);

   if (!is_pow2(nrOfEntries)) begin : g_badDepth
      $error("fifo_level: nrOfEntries must be a power of two >= 2");
   end

   logic [PW-1:0]       r_wrPtr;
   logic [PW-1:0]       r_rdPtr;
   logic [LW-1:0]       r_level;
   logic                r_overflow;
   logic                r_underflow;
   logic                w_full;
   logic                w_empty;
   logic                w_pushAcc;
   logic                w_popAcc;
   logic [bitWidth-1:0] w_rdData;

   assign w_full    = (r_level == DEPTH);
   assign w_empty   = (r_level == '0);
   // A pop on a full FIFO frees the slot the push lands in
   assign w_pushAcc = push & (~w_full | pop);
   assign w_popAcc  = pop & ~w_empty;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wrPtr     <= '0;
         r_rdPtr     <= '0;
         r_level     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_pushAcc) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_popAcc)  r_rdPtr <= r_rdPtr + 1'b1;
         if (w_pushAcc && !w_popAcc)
            r_level <= r_level + 1'b1;
         else if (w_popAcc && !w_pushAcc)
            r_level <= r_level - 1'b1;
         if (clearErrors) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
         end else begin
            if (push & w_full & ~pop) r_overflow  <= 1'b1;
            if (pop & w_empty)        r_underflow <= 1'b1;
         end
      end
   end

   fifo_dual_port_ram #(
      .depth (nrOfEntries),
      .width (bitWidth)
   ) u_ram (
      .clock  (clock),
      .wrEn   (w_pushAcc),
      .wrAddr (r_wrPtr),
      .wrData (pushData),
      .rdAddr (r_rdPtr),
      .rdData (w_rdData)
   );

   if (showAhead == SHOW_AHEAD) begin : g_show
      assign popData  = w_rdData;
      assign popValid = ~w_empty;
   end else begin : g_reg
      logic [bitWidth-1:0] r_popData;
      logic                r_popValid;

      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            r_popData  <= '0;
            r_popValid <= 1'b0;
         end else begin
            r_popValid <= w_popAcc;
            if (w_popAcc) r_popData <= w_rdData;
         end
      end

      assign popData  = r_popData;
      assign popValid = r_popValid;
   end

   assign full        = w_full;
   assign empty       = w_empty;
   assign fillLevel   = r_level;
   assign almostFull  = (r_level >= afLevel);
   assign almostEmpty = (r_level <= aeLevel);
   assign overflow    = r_overflow;
   assign underflow   = r_underflow;

endmodule

// File: tb/tb_fifo_level.sv
// Bench for fifo_level: show-ahead and registered instances
// driven in lockstep, checked against a queue-based model.
module tb_fifo_level;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       push = 1'b0;
   logic [7:0] pushData = '0;
   logic       pop = 1'b0;
   logic       clearErrors = 1'b0;
   logic [3:0] af = 4'd6;
   logic [3:0] ae = 4'd2;

   logic [7:0] aData, bData;
   logic       aValid, bValid;
   logic       aFull, bFull, aEmpty, bEmpty;
   logic [3:0] aFill, bFill;
   logic       aAF, bAF, aAE, bAE;
   logic       aOv, bOv, aUn, bUn;

   int checks = 0;
   int errors = 0;

   logic [7:0] q[$];
   bit         mOv = 0;
   bit         mUn = 0;
   bit         mValid = 0;
   logic [7:0] mRegData = '0;

   always #5 clock = ~clock;

   fifo_level #(
      .nrOfEntries (8),
      .bitWidth    (8),
      .showAhead   (1)
   ) u_dutA (
      .clock       (clock),
      .reset       (reset),
      .push        (push),
      .pushData    (pushData),
      .pop         (pop),
      .popData     (aData),
      .popValid    (aValid),
      .full        (aFull),
      .empty       (aEmpty),
      .fillLevel   (aFill),
      .afLevel     (af),
      .aeLevel     (ae),
      .almostFull  (aAF),
      .almostEmpty (aAE),
      .overflow    (aOv),
      .underflow   (aUn),
      .clearErrors (clearErrors)
   );

   fifo_level #(
      .nrOfEntries (8),
      .bitWidth    (8),
      .showAhead   (0)
   ) u_dutB (
      .clock       (clock),
      .reset       (reset),
      .push        (push),
      .pushData    (pushData),
      .pop         (pop),
      .popData     (bData),
      .popValid    (bValid),
      .full        (bFull),
      .empty       (bEmpty),
      .fillLevel   (bFill),
      .afLevel     (af),
      .aeLevel     (ae),
      .almostFull  (bAF),
      .almostEmpty (bAE),
      .overflow    (bOv),
      .underflow   (bUn),
      .clearErrors (clearErrors)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h",
                  tag, obs, exp);
      end
   endtask

   task automatic check_all();
      int n;
      n = q.size();
      chk("A.fill", 32'(aFill), 32'(n));
      chk("A.full", 32'(aFull), 32'(n == 8));
      chk("A.empty", 32'(aEmpty), 32'(n == 0));
      chk("A.af", 32'(aAF), 32'(n >= int'(af)));
      chk("A.ae", 32'(aAE), 32'(n <= int'(ae)));
      chk("A.ovf", 32'(aOv), 32'(mOv));
      chk("A.unf", 32'(aUn), 32'(mUn));
      chk("A.valid", 32'(aValid), 32'(n != 0));
      if (n != 0) chk("A.data", 32'(aData), 32'(q[0]));
      chk("B.fill", 32'(bFill), 32'(n));
      chk("B.full", 32'(bFull), 32'(n == 8));
      chk("B.ovf", 32'(bOv), 32'(mOv));
      chk("B.unf", 32'(bUn), 32'(mUn));
      chk("B.valid", 32'(bValid), 32'(mValid));
      chk("B.data", 32'(bData), 32'(mRegData));
   endtask

   task automatic model_reset();
      q.delete();
      mOv = 0;
      mUn = 0;
      mValid = 0;
      mRegData = '0;
   endtask

   task automatic step(input bit ps, input logic [7:0] d,
                       input bit pp, input bit clr);
      int  n;
      bit  pa, pc;
      push = ps;
      pushData = d;
      pop = pp;
      clearErrors = clr;
      @(posedge clock);
      n = q.size();
      pa = ps && (n < 8 || pp);
      pc = pp && (n > 0);
      if (clr) begin
         mOv = 0;
         mUn = 0;
      end else begin
         if (ps && n == 8 && !pp) mOv = 1;
         if (pp && n == 0) mUn = 1;
      end
      if (pc) begin
         mRegData = q.pop_front();
         mValid = 1;
      end else begin
         mValid = 0;
      end
      if (pa) q.push_back(d);
      @(negedge clock);
      push = 0;
      pop = 0;
      clearErrors = 0;
      check_all();
   endtask

   initial begin
      repeat (2) @(negedge clock);
      check_all();
      chk("rst.bData", 32'(bData), 32'h0);
      reset = 1'b1;
      @(negedge clock);

      for (int i = 0; i < 3; i++)
         step(1, 8'($urandom), 0, 0);
      #2 reset = 1'b0;
      #1;
      chk("mid.fill", 32'(aFill), 32'h0);
      chk("mid.empty", 32'(aEmpty), 32'h1);
      model_reset();
      @(negedge clock);
      reset = 1'b1;
      check_all();
      step(1, 8'hAA, 0, 0);
      chk("mid.AA", 32'(aData), 32'hAA);
      step(0, 8'h00, 1, 0);

      for (int i = 0; i < 8; i++)
         step(1, 8'(8'h05 + i), 0, 0);
      chk("fill.full", 32'(aFull), 32'h1);

      step(1, 8'hFF, 0, 0);
      chk("ovf.set", 32'(aOv), 32'h1);
      chk("ovf.fill", 32'(aFill), 32'h8);
      step(0, 8'h00, 0, 1);
      chk("ovf.clr", 32'(aOv), 32'h0);

      for (int i = 0; i < 10; i++)
         step(1, 8'(8'h20 + i), 1, 0);
      for (int i = 0; i < 8; i++)
         step(0, 8'h00, 1, 0);
      chk("drain.empty", 32'(aEmpty), 32'h1);

      step(1, 8'h33, 1, 0);
      chk("unf.set", 32'(aUn), 32'h1);
      chk("unf.fill", 32'(aFill), 32'h1);
      step(0, 8'h00, 1, 1);

      step(1, 8'h11, 0, 0);
      step(1, 8'h22, 0, 0);
      step(0, 8'h00, 1, 0);
      chk("reg.d0", 32'(bData), 32'h11);
      step(0, 8'h00, 1, 0);
      chk("reg.d1", 32'(bData), 32'h22);
      step(0, 8'h00, 0, 0);
      chk("reg.idle", 32'(bValid), 32'h0);

      for (int i = 0; i < 4; i++)
         step(1, 8'($urandom), 0, 0);
      af = 4'd4;
      #1 chk("thr.af", 32'(aAF), 32'(q.size() >= 4));
      ae = 4'd5;
      #1 chk("thr.ae", 32'(aAE), 32'(q.size() <= 5));
      @(negedge clock);
      check_all();
      af = 4'd6;
      ae = 4'd2;

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            af = 4'($urandom_range(0, 8));
            ae = 4'($urandom_range(0, 8));
         end
         step(bit'($urandom_range(0, 1)), 8'($urandom),
              bit'($urandom_range(0, 1)),
              $urandom_range(0, 19) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
